// File: rtl/ring_node_if.sv
// Ring node network interface: core tx queue toward the ring, rx queue toward core.
// Define RING_NODE_IF_LOOPBACK_EN to turn self-addressed packets around locally.
module ring_node_if #(
  parameter int NODE_ID      = 0,
  parameter int ID_SIZE      = 8,
  parameter int DATA_WIDTH   = 128,
  parameter int TXQ_DEPTH    = 4,
  parameter int RXQ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 16,
  localparam int PKT_W = 2*ID_SIZE+DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_tx_valid,
  output logic                  core_tx_ready,
  input  logic [ID_SIZE-1:0]    core_tx_dest,
  input  logic [DATA_WIDTH-1:0] core_tx_data,
  output logic [PKT_W-1:0]      ring_pkt_out,
  output logic                  ring_pkt_valid,
  input  logic                  ring_accept,
  input  logic                  ring_rx_valid,
  input  logic [PKT_W-1:0]      ring_rx_pkt,
  output logic                  core_rx_valid,
  input  logic                  core_rx_ready,
  output logic [ID_SIZE-1:0]    core_rx_src,
  output logic [DATA_WIDTH-1:0] core_rx_data,
  output logic                  tx_starved,
  output logic [15:0]           rx_drop_cnt
);

  localparam int TAW = $clog2(TXQ_DEPTH);
  localparam int RAW = $clog2(RXQ_DEPTH);
  localparam int SW0 = $clog2(STARVE_LIMIT+1);
  localparam int SW  = (SW0 < 5) ? 5 : SW0;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [PKT_W-1:0] txq [TXQ_DEPTH];
  logic [TAW-1:0]   tx_wp, tx_rp;
  logic [TAW:0]     tx_cnt, tx_cnt_n;
  logic [PKT_W-1:0] rxq [RXQ_DEPTH];
  logic [RAW-1:0]   rx_wp, rx_rp;
  logic [RAW:0]     rx_cnt;
  logic [0:0]       state;
  logic [SW-1:0]    starve_cnt;

  logic [PKT_W-1:0] tx_head, rx_head, rx_din;
  logic tx_full, rx_full, head_self;
  logic tx_push, tx_pop, take, lb_move;
  logic rx_push, rx_pop, rx_drop;
  logic [ID_SIZE-1:0] rx_dest_unused;

  assign tx_head = txq[tx_rp];
  assign rx_head = rxq[rx_rp];
  assign tx_full = (tx_cnt == (TAW+1)'(TXQ_DEPTH));
  assign rx_full = (rx_cnt == (RAW+1)'(RXQ_DEPTH));

`ifdef RING_NODE_IF_LOOPBACK_EN
  assign head_self =
    (tx_head[DATA_WIDTH +: ID_SIZE] == ID_SIZE'(NODE_ID));
`else
  assign head_self = 1'b0;
`endif

  assign core_tx_ready  = !tx_full;
  assign ring_pkt_valid = (state == S_OFFER) && !head_self;
  assign ring_pkt_out   = ring_pkt_valid ? tx_head : '0;

  assign tx_push = core_tx_valid && core_tx_ready;
  assign take    = ring_pkt_valid && ring_accept;
  // ring deliveries win the rx write port over local turnaround
  assign lb_move = (state == S_OFFER) && head_self
                && !rx_full && !ring_rx_valid;
  assign tx_pop  = take || lb_move;
  assign tx_cnt_n = tx_cnt + (TAW+1)'(tx_push)
                  - (TAW+1)'(tx_pop);

  assign core_rx_valid = (rx_cnt != '0);
  assign rx_pop  = core_rx_valid && core_rx_ready;
  assign rx_push = (ring_rx_valid && (!rx_full || rx_pop))
                || lb_move;
  assign rx_drop = ring_rx_valid && rx_full && !rx_pop;
  assign rx_din  = ring_rx_valid ? ring_rx_pkt : tx_head;

  assign core_rx_src  = core_rx_valid ?
    rx_head[DATA_WIDTH+ID_SIZE +: ID_SIZE] : '0;
  assign core_rx_data = core_rx_valid ?
    rx_head[DATA_WIDTH-1:0] : '0;
  assign rx_dest_unused = rx_head[DATA_WIDTH +: ID_SIZE];

  always_ff @(posedge clk) begin
    if (tx_push)
      txq[tx_wp] <= {ID_SIZE'(NODE_ID), core_tx_dest, core_tx_data};
    if (rx_push)
      rxq[rx_wp] <= rx_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      state  <= S_IDLE;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt_n;
      state  <= (tx_cnt_n != '0) ? S_OFFER : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt  <= '0;
      tx_starved  <= 1'b0;
      rx_drop_cnt <= '0;
    end else begin
      if (take) begin
        starve_cnt <= '0;
        tx_starved <= 1'b0;
      end else if (ring_pkt_valid &&
                   starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
        if (starve_cnt == SW'(STARVE_LIMIT-1))
          tx_starved <= 1'b1;
      end
      if (rx_drop && rx_drop_cnt != 16'hFFFF)
        rx_drop_cnt <= rx_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_node_if.sv
// Bench for ring_node_if: queue-level model checked every cycle plus literals.
// Build with RING_NODE_IF_LOOPBACK_EN to exercise local turnaround.
module tb_ring_node_if;

`ifdef RING_NODE_IF_LOOPBACK_EN
  localparam int LB  = 1;
  localparam int NID = 1;
`else
  localparam int LB  = 0;
  localparam int NID = 0;
`endif

  typedef logic [143:0] pkt_t;
  localparam logic [7:0] NID8 = 8'(NID);

  logic clk, reset;
  logic core_tx_valid, core_tx_ready;
  logic [7:0] core_tx_dest;
  logic [127:0] core_tx_data;
  pkt_t ring_pkt_out;
  logic ring_pkt_valid, ring_accept, ring_rx_valid;
  pkt_t ring_rx_pkt;
  logic core_rx_valid, core_rx_ready;
  logic [7:0] core_rx_src;
  logic [127:0] core_rx_data;
  logic tx_starved;
  logic [15:0] rx_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ring_node_if #(.NODE_ID(NID)) dut (
    .clk(clk), .reset(reset),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_tx_dest(core_tx_dest), .core_tx_data(core_tx_data),
    .ring_pkt_out(ring_pkt_out), .ring_pkt_valid(ring_pkt_valid),
    .ring_accept(ring_accept), .ring_rx_valid(ring_rx_valid),
    .ring_rx_pkt(ring_rx_pkt), .core_rx_valid(core_rx_valid),
    .core_rx_ready(core_rx_ready), .core_rx_src(core_rx_src),
    .core_rx_data(core_rx_data), .tx_starved(tx_starved),
    .rx_drop_cnt(rx_drop_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, pkt_t act, pkt_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic pkt_t mk(int s, int d, int v);
    return {8'(s), 8'(d), 128'(v)};
  endfunction

  // queue-level model
  pkt_t mtx[$];
  pkt_t mrx[$];
  int mstarve = 0;
  bit mstarved = 0;
  int mdrop = 0;
  bit armed = 0;

  always @(posedge clk) begin
    pkt_t h;
    bit self, v, take, rxpop, txpush, lb, rfull;
    if (reset) begin
      mtx.delete(); mrx.delete();
      mstarve = 0; mstarved = 0; mdrop = 0; armed = 1;
    end else if (armed) begin
      h = (mtx.size() > 0) ? mtx[0] : '0;
      self = (LB != 0) && mtx.size() > 0 && h[135:128] == NID8;
      v = mtx.size() > 0 && !self;
      take = v && ring_accept;
      rxpop = mrx.size() > 0 && core_rx_ready;
      txpush = core_tx_valid && mtx.size() < 4;
      lb = self && mrx.size() < 4 && !ring_rx_valid;
      rfull = mrx.size() == 4;
      if (rxpop) void'(mrx.pop_front());
      if (ring_rx_valid) begin
        if (!rfull || rxpop) mrx.push_back(ring_rx_pkt);
        else if (mdrop < 65535) mdrop++;
      end
      if (lb) mrx.push_back(h);
      if (take || lb) void'(mtx.pop_front());
      if (txpush) mtx.push_back({NID8, core_tx_dest, core_tx_data});
      if (take) begin
        mstarve = 0; mstarved = 0;
      end else if (v && mstarve < 16) begin
        mstarve++;
        if (mstarve == 16) mstarved = 1;
      end
    end
    #1;
    if (armed) begin
      h = (mtx.size() > 0) ? mtx[0] : '0;
      self = (LB != 0) && mtx.size() > 0 && h[135:128] == NID8;
      v = mtx.size() > 0 && !self;
      chk("m_tx_ready", core_tx_ready, mtx.size() < 4);
      chk("m_pkt_valid", ring_pkt_valid, v);
      chk("m_pkt_out", ring_pkt_out, v ? h : '0);
      h = (mrx.size() > 0) ? mrx[0] : '0;
      chk("m_rx_valid", core_rx_valid, mrx.size() > 0);
      chk("m_rx_src", core_rx_src, h[143:136]);
      chk("m_rx_data", core_rx_data, h[127:0]);
      chk("m_starved", tx_starved, mstarved);
      chk("m_drop", rx_drop_cnt, mdrop);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; core_tx_valid = 0; core_tx_dest = 0;
    core_tx_data = 0; ring_accept = 0; ring_rx_valid = 0;
    ring_rx_pkt = 0; core_rx_ready = 0;
    repeat (2) tick();
    reset = 0;
    chk("rst_pkt_valid", ring_pkt_valid, 0);
    chk("rst_rx_valid", core_rx_valid, 0);
    chk("rst_drop", rx_drop_cnt, 0);
    tick();
    chk("rst_tx_ready", core_tx_ready, 1);

    // single packet held 4 cycles under back-pressure
    core_tx_valid = 1; core_tx_dest = 8'h02;
    core_tx_data = 128'h1234;
    tick();
    core_tx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      ring_accept = (i == 3);
      chk("t1_valid", ring_pkt_valid, 1);
      chk("t1_out", ring_pkt_out, {NID8, 8'h02, 128'h1234});
      tick();
    end
    ring_accept = 0;
    chk("t1_valid_drop", ring_pkt_valid, 0);

    // fill txq, hold a 5th, release one slot
    for (int k = 1; k <= 4; k++) begin
      core_tx_valid = 1; core_tx_dest = 8'h05;
      core_tx_data = 128'(k);
      tick();
    end
    core_tx_data = 128'(5);
    chk("t2_full", core_tx_ready, 0);
    repeat (2) tick();
    ring_accept = 1;
    tick();
    ring_accept = 0;
    chk("t2_ready_back", core_tx_ready, 1);
    chk("t2_head", ring_pkt_out[127:0], 2);
    tick();
    core_tx_valid = 0;
    for (int k = 2; k <= 5; k++) begin
      chk("t2_order", ring_pkt_out[127:0], 128'(k));
      ring_accept = 1;
      tick();
    end
    ring_accept = 0;
    chk("t2_empty", ring_pkt_valid, 0);

    // starvation
    core_tx_valid = 1; core_tx_dest = 8'h07;
    core_tx_data = 128'h99;
    tick();
    core_tx_valid = 0;
    for (int c = 1; c <= 16; c++) begin
      chk("t3_not_starved", tx_starved, 0);
      tick();
    end
    chk("t3_starved", tx_starved, 1);
    repeat (3) tick();
    chk("t3_sticky", tx_starved, 1);
    ring_accept = 1;
    tick();
    ring_accept = 0;
    chk("t3_cleared", tx_starved, 0);

    // rx overflow and drain
    for (int k = 1; k <= 5; k++) begin
      ring_rx_valid = 1; ring_rx_pkt = mk(3, NID, k);
      tick();
    end
    ring_rx_valid = 0;
    chk("t4_drop", rx_drop_cnt, 1);
    core_rx_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_data", core_rx_data, 128'(k));
      chk("t4_src", core_rx_src, 3);
      tick();
    end
    core_rx_ready = 0;
    chk("t4_empty", core_rx_valid, 0);

    // full rxq: push and pop in one cycle
    for (int k = 11; k <= 14; k++) begin
      ring_rx_valid = 1; ring_rx_pkt = mk(6, NID, k);
      tick();
    end
    ring_rx_pkt = mk(6, NID, 15); core_rx_ready = 1;
    tick();
    ring_rx_valid = 0; core_rx_ready = 0;
    chk("t5_no_drop", rx_drop_cnt, 1);
    chk("t5_head", core_rx_data, 12);
    core_rx_ready = 1;
    for (int k = 12; k <= 15; k++) begin
      chk("t5_data", core_rx_data, 128'(k));
      tick();
    end
    core_rx_ready = 0;
    chk("t5_empty", core_rx_valid, 0);

    // self-addressed packet
    core_tx_valid = 1; core_tx_dest = NID8;
    core_tx_data = 128'hAA;
    tick();
    core_tx_valid = 0;
`ifdef RING_NODE_IF_LOOPBACK_EN
    chk("t6_no_offer", ring_pkt_valid, 0);
    tick();
    chk("t6_rx_valid", core_rx_valid, 1);
    chk("t6_rx_data", core_rx_data, 128'hAA);
    chk("t6_rx_src", core_rx_src, NID8);
    core_rx_ready = 1;
    tick();
    core_rx_ready = 0;
`else
    chk("t6_offer", ring_pkt_valid, 1);
    chk("t6_out", ring_pkt_out, {NID8, NID8, 128'hAA});
    ring_accept = 1;
    tick();
    ring_accept = 0;
`endif

    // reset mid-operation
    for (int k = 1; k <= 3; k++) begin
      core_tx_valid = (k <= 2); core_tx_dest = 8'h04;
      core_tx_data = 128'(k);
      ring_rx_valid = 1; ring_rx_pkt = mk(2, NID, k);
      tick();
    end
    core_tx_valid = 0; ring_rx_valid = 0;
    chk("t7_pre", core_rx_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t7_pkt_valid", ring_pkt_valid, 0);
    chk("t7_pkt_out", ring_pkt_out, 0);
    chk("t7_rx_valid", core_rx_valid, 0);
    chk("t7_rx_src", core_rx_src, 0);
    chk("t7_rx_data", core_rx_data, 0);
    chk("t7_starved", tx_starved, 0);
    chk("t7_drop", rx_drop_cnt, 0);
    chk("t7_tx_ready", core_tx_ready, 1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
